// File: rtl/booth_pkg.sv
// Shared constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Booth step selects, indexed by {Q[0], q_1}
   localparam logic [1:0] BOOTH_NOP     = 2'b00;
   localparam logic [1:0] BOOTH_NOP_ALT = 2'b11;
   localparam logic [1:0] BOOTH_ADD     = 2'b01;
   localparam logic [1:0] BOOTH_SUB     = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/sub of M into A, then an arithmetic
// right shift of {A, Q, q_1}.
module booth_step
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] q,
   input  logic             q_1,
   input  logic [WIDTH:0]   m,
   output logic [WIDTH:0]   a_next_c,
   output logic [WIDTH-1:0] q_next_c,
   output logic             q_1_next_c
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum = a;
      case ({q[0], q_1})
         BOOTH_ADD: sum = a + m;
         BOOTH_SUB: sum = a - m;
         default:   sum = a;
      endcase
      // A is one bit wider than the operands, so the sign bit never overflows
      a_next_c   = {sum[WIDTH], sum[WIDTH:1]};
      q_next_c   = {sum[0], q[WIDTH-1:1]};
      q_1_next_c = q[0];
   end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: WIDTH steps per product, start/busy/done.
// Optional one-deep start queue with a ready port under BOOTH_START_QUEUE_EN.
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
`ifdef BOOTH_START_QUEUE_EN
   ,
   output logic                 ready
`endif
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [0:0]         state, state_nxt;
   logic [WIDTH:0]     a, a_nxt, m, m_nxt;
   logic [WIDTH-1:0]   q, q_nxt;
   logic               q_1, q_1_nxt;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic               done_nxt;
   logic [2*WIDTH-1:0] product_nxt;

   logic [WIDTH:0]     a_step;
   logic [WIDTH-1:0]   q_step;
   logic               q_1_step;

   logic               load;
   logic [WIDTH-1:0]   ld_m, ld_q;

`ifdef BOOTH_START_QUEUE_EN
   logic               pend_vld, pend_vld_nxt;
   logic [WIDTH-1:0]   pend_m, pend_m_nxt, pend_q, pend_q_nxt;

   assign ready = ~pend_vld;
`endif

   assign busy = (state == ST_RUN);

   booth_step #(.WIDTH(WIDTH)) u_step (
      .a          (a),
      .q          (q),
      .q_1        (q_1),
      .m          (m),
      .a_next_c   (a_step),
      .q_next_c   (q_step),
      .q_1_next_c (q_1_step)
   );

   // Next-state, datapath and output logic
   always_comb begin
      state_nxt   = state;
      a_nxt       = a;
      q_nxt       = q;
      q_1_nxt     = q_1;
      m_nxt       = m;
      cnt_nxt     = cnt;
      done_nxt    = 1'b0;
      product_nxt = product;
      load        = 1'b0;
      ld_m        = multiplicand;
      ld_q        = multiplier;
`ifdef BOOTH_START_QUEUE_EN
      pend_vld_nxt = pend_vld;
      pend_m_nxt   = pend_m;
      pend_q_nxt   = pend_q;
`endif

      case (state)
         ST_IDLE: begin
            if (start) load = 1'b1;
         end
         ST_RUN: begin
            a_nxt   = a_step;
            q_nxt   = q_step;
            q_1_nxt = q_1_step;
            cnt_nxt = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               product_nxt = {a_step[WIDTH-1:0], q_step};
               done_nxt    = 1'b1;
               state_nxt   = ST_IDLE;
`ifdef BOOTH_START_QUEUE_EN
               // Chain straight into the next operation with no idle cycle
               if (pend_vld) begin
                  load         = 1'b1;
                  ld_m         = pend_m;
                  ld_q         = pend_q;
                  pend_vld_nxt = 1'b0;
               end else if (start) begin
                  load = 1'b1;
               end
            end else if (start && !pend_vld) begin
               pend_vld_nxt = 1'b1;
               pend_m_nxt   = multiplicand;
               pend_q_nxt   = multiplier;
`endif
            end
         end
      endcase

      if (load) begin
         state_nxt = ST_RUN;
         m_nxt     = {ld_m[WIDTH-1], ld_m};
         a_nxt     = '0;
         q_nxt     = ld_q;
         q_1_nxt   = 1'b0;
         cnt_nxt   = CW'(WIDTH);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         a       <= '0;
         q       <= '0;
         q_1     <= 1'b0;
         m       <= '0;
         cnt     <= '0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         state   <= state_nxt;
         a       <= a_nxt;
         q       <= q_nxt;
         q_1     <= q_1_nxt;
         m       <= m_nxt;
         cnt     <= cnt_nxt;
         done    <= done_nxt;
         product <= product_nxt;
      end
   end

`ifdef BOOTH_START_QUEUE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_vld <= 1'b0;
         pend_m   <= '0;
         pend_q   <= '0;
      end else begin
         pend_vld <= pend_vld_nxt;
         pend_m   <= pend_m_nxt;
         pend_q   <= pend_q_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq at WIDTH=4 and WIDTH=8, against a
// plain signed-multiply reference; also exercises BOOTH_START_QUEUE_EN when defined.
module tb_booth_mult_seq;

   logic        clk = 1'b0;
   logic        reset;

   logic        start4;
   logic [3:0]  mc4, mp4;
   logic        busy4, done4;
   logic [7:0]  product4;

   logic        start8;
   logic [7:0]  mc8, mp8;
   logic        busy8, done8;
   logic [15:0] product8;

`ifdef BOOTH_START_QUEUE_EN
   logic        ready4, ready8;
   localparam int POKE = 0;
`else
   localparam int POKE = 2;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   booth_mult_seq #(.WIDTH(4)) u_dut4 (
      .clk          (clk),
      .reset        (reset),
      .start        (start4),
      .multiplicand (mc4),
      .multiplier   (mp4),
      .busy         (busy4),
      .done         (done4),
      .product      (product4)
`ifdef BOOTH_START_QUEUE_EN
      ,
      .ready        (ready4)
`endif
   );

   booth_mult_seq #(.WIDTH(8)) u_dut8 (
      .clk          (clk),
      .reset        (reset),
      .start        (start8),
      .multiplicand (mc8),
      .multiplier   (mp8),
      .busy         (busy8),
      .done         (done8),
      .product      (product8)
`ifdef BOOTH_START_QUEUE_EN
      ,
      .ready        (ready8)
`endif
   );

   function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b);
      int x, y;
      x = $signed(a);
      y = $signed(b);
      return 8'(x * y);
   endfunction

   function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
      int x, y;
      x = $signed(a);
      y = $signed(b);
      return 16'(x * y);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive a start for one edge; operands are scrambled afterwards
   task automatic go4(input logic [3:0] a, input logic [3:0] b);
      start4 = 1'b1; mc4 = a; mp4 = b;
      @(posedge clk); #1;
      start4 = 1'b0; mc4 = 4'($urandom); mp4 = 4'($urandom);
      check("acc4_busy", 32'(busy4), 32'd1);
      check("acc4_done", 32'(done4), 32'd0);
   endtask

   task automatic wait4(input logic [7:0] exp, input int poke);
      for (int i = 1; i <= 4; i++) begin
         if (i == poke) begin
            start4 = 1'b1; mc4 = 4'($urandom); mp4 = 4'($urandom);
         end
         @(posedge clk); #1;
         start4 = 1'b0;
         if (i < 4) begin
            check("run4_done", 32'(done4), 32'd0);
            check("run4_busy", 32'(busy4), 32'd1);
         end else begin
            check("done4", 32'(done4), 32'd1);
            check("prod4", 32'(product4), 32'(exp));
            check("idle4_busy", 32'(busy4), 32'd0);
         end
      end
   endtask

   task automatic go8(input logic [7:0] a, input logic [7:0] b);
      start8 = 1'b1; mc8 = a; mp8 = b;
      @(posedge clk); #1;
      start8 = 1'b0; mc8 = 8'($urandom); mp8 = 8'($urandom);
      check("acc8_busy", 32'(busy8), 32'd1);
      check("acc8_done", 32'(done8), 32'd0);
   endtask

   task automatic wait8(input logic [15:0] exp);
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (i < 8) begin
            check("run8_done", 32'(done8), 32'd0);
         end else begin
            check("done8", 32'(done8), 32'd1);
            check("prod8", 32'(product8), 32'(exp));
            check("idle8_busy", 32'(busy8), 32'd0);
         end
      end
   endtask

   initial begin
      logic [7:0] edges [5];
      logic [3:0] ra, rb;
      logic [7:0] sa, sb;
      edges = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F};

      reset = 1'b1;
      start4 = 1'b0; mc4 = '0; mp4 = '0;
      start8 = 1'b0; mc8 = '0; mp8 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy4", 32'(busy4), 32'd0);
      check("rst_done4", 32'(done4), 32'd0);
      check("rst_prod4", 32'(product4), 32'd0);
      check("rst_prod8", 32'(product8), 32'd0);
`ifdef BOOTH_START_QUEUE_EN
      check("rst_ready4", 32'(ready4), 32'd1);
`endif
      reset = 1'b0;

      // Directed WIDTH=4 vectors
      go4(4'd3, 4'hE);  wait4(8'hFA, 0);
      go4(4'h8, 4'h8);  wait4(8'h40, 0);
      go4(4'd7, 4'h8);  wait4(8'hC8, 0);
      // Back-to-back start in the done cycle, with a stray start mid-run
      go4(4'hF, 4'hF);  wait4(8'h01, POKE);
      go4(4'd0, 4'd5);  wait4(8'h00, 0);
      @(posedge clk); #1;
      check("done4_pulse", 32'(done4), 32'd0);

      // Reset two steps into a run
      go4(4'd3, 4'hE);
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      check("abort_busy", 32'(busy4), 32'd0);
      check("abort_prod", 32'(product4), 32'd0);
      check("abort_done", 32'(done4), 32'd0);
      @(posedge clk); #1;
      check("abort_nodone", 32'(done4), 32'd0);
      reset = 1'b0;
      go4(4'd5, 4'd3);  wait4(8'h0F, 0);

      for (int n = 0; n < 30; n++) begin
         ra = 4'($urandom); rb = 4'($urandom);
         go4(ra, rb); wait4(ref4(ra, rb), 0);
      end

      // WIDTH=8 edge sweep and random operands
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            go8(edges[i], edges[j]); wait8(ref8(edges[i], edges[j]));
         end
      for (int n = 0; n < 10; n++) begin
         sa = 8'($urandom); sb = 8'($urandom);
         go8(sa, sb); wait8(ref8(sa, sb));
      end
      @(posedge clk); #1;
      check("done8_pulse", 32'(done8), 32'd0);

`ifdef BOOTH_START_QUEUE_EN
      // Queue a second operation while the first runs
      go4(4'd2, 4'd3);
      start4 = 1'b1; mc4 = 4'hC; mp4 = 4'd5;
      @(posedge clk); #1;
      start4 = 1'b0;
      check("q_ready_low", 32'(ready4), 32'd0);
      check("q_busy", 32'(busy4), 32'd1);
      repeat (2) begin @(posedge clk); #1; check("q_run_done", 32'(done4), 32'd0); end
      @(posedge clk); #1;
      check("q_done1", 32'(done4), 32'd1);
      check("q_prod1", 32'(product4), 32'h06);
      check("q_nogap_busy", 32'(busy4), 32'd1);
      repeat (3) begin @(posedge clk); #1; check("q_run2_done", 32'(done4), 32'd0); end
      @(posedge clk); #1;
      check("q_done2", 32'(done4), 32'd1);
      check("q_prod2", 32'(product4), 32'hEC);
      check("q_ready_high", 32'(ready4), 32'd1);
      check("q_idle_busy", 32'(busy4), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
